// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - hazard/stall/flush sequencing controller for a 5-stage MIPS pipeline
module hazard_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             clr_stats,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  // Remaining flush cycles loaded when a taken branch leaves RUN (the RUN cycle itself is the first flush).
  localparam logic [2:0] LP_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit         LP_MULTI_FLUSH = (FLUSH_CYCLES > 1);

  state_t           r_state;
  state_t           r_ret_state;
  logic [2:0]       r_flush_cnt;
  logic [CNT_W-1:0] r_stall_count;

  state_t           w_next_state;
  state_t           w_next_ret;
  state_t           w_eff_state;
  logic [2:0]       w_next_flush_cnt;
  logic             w_lu_hazard;

  // Load-use: the load in EX writes a register the ID instruction reads ($zero never counts).
  assign w_lu_hazard = idex_mem_read && (idex_rt != 5'd0) &&
                       ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // A FREEZE cycle with memory ready behaves exactly like the state it interrupted.
  assign w_eff_state = ((r_state == ST_FREEZE) && !mem_busy) ? r_ret_state : r_state;

  // State, return-state and flush-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_next_state;
      r_ret_state <= w_next_ret;
      r_flush_cnt <= w_next_flush_cnt;
    end
  end

  // Next-state and pipeline control outputs; priority mem_busy > load-use > branch.
  always_comb begin
    w_next_state     = ST_RUN;
    w_next_ret       = r_ret_state;
    w_next_flush_cnt = r_flush_cnt;
    pc_write         = 1'b0;
    ifid_write       = 1'b0;
    ifid_flush       = 1'b0;
    idex_bubble      = 1'b0;
    freeze           = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      freeze       = 1'b1;
      w_next_state = ST_FREEZE;
      if (r_state != ST_FREEZE) begin
        w_next_ret = r_state;
      end
    end else begin
      case (w_eff_state)
        ST_RUN: begin
          w_next_state = ST_RUN;
          if (w_lu_hazard) begin
            idex_bubble = 1'b1;
          end else if (branch_taken) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            if (LP_MULTI_FLUSH) begin
              w_next_flush_cnt = LP_FLUSH_LOAD;
              w_next_state     = ST_FLUSH;
            end
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        ST_FLUSH: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          if (r_flush_cnt <= 3'd1) begin
            w_next_flush_cnt = 3'd0;
            w_next_state     = ST_RUN;
          end else begin
            w_next_flush_cnt = r_flush_cnt - 3'd1;
            w_next_state     = ST_FLUSH;
          end
        end
        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (clr_stats) begin
      r_stall_count <= '0;
    end else if (!pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       idex_mem_read;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       ifid_uses_rt;
  logic       branch_taken;
  logic       mem_busy;
  logic       clr_stats;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       freeze;
  logic [3:0] stall_count;

  int checks = 0;
  int errors = 0;

  hazard_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_uses_rt  (ifid_uses_rt),
    .branch_taken  (branch_taken),
    .mem_busy      (mem_busy),
    .clr_stats     (clr_stats),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .freeze        (freeze),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ur, input logic br,
                        input logic busy, input logic clr);
    idex_mem_read = mr;
    idex_rt       = xrt;
    ifid_rs       = rs;
    ifid_rt       = rt;
    ifid_uses_rt  = ur;
    branch_taken  = br;
    mem_busy      = busy;
    clr_stats     = clr;
    #1;
  endtask

  // exp = {pc_write, ifid_write, ifid_flush, idex_bubble, freeze}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {pc_write, ifid_write, ifid_flush, idex_bubble, freeze};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: ctl observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] exp);
    checks++;
    assert (stall_count === exp) else begin
      errors++;
      $error("FAIL %s: stall_count observed %0d expected %0d", tag, stall_count, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("reset_ctl", 5'b00110);
    chk_cnt("reset_cnt", 4'd0);
    nxt;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("idle_run", 5'b11000);
    nxt;

    // load-use on rs
    set_in(1, 9, 9, 4, 0, 0, 0, 0);
    chk_ctl("lu_rs_stall", 5'b00010);
    nxt;
    set_in(0, 9, 9, 4, 0, 0, 0, 0);
    chk_ctl("lu_after", 5'b11000);
    chk_cnt("lu_cnt", 4'd1);
    nxt;

    // no false stalls, then a genuine rt match
    set_in(1, 0, 0, 0, 1, 0, 0, 0);
    chk_ctl("zero_reg_no_stall", 5'b11000);
    nxt;
    set_in(1, 9, 3, 9, 0, 0, 0, 0);
    chk_ctl("rt_unused_no_stall", 5'b11000);
    nxt;
    set_in(1, 9, 3, 9, 1, 0, 0, 0);
    chk_ctl("rt_used_stall", 5'b00010);
    nxt;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk_cnt("rt_cnt", 4'd2);

    // taken branch: three flush cycles, hazard ignored while flushing
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    chk_ctl("br_flush1", 5'b11100);
    nxt;
    set_in(1, 9, 9, 0, 0, 0, 0, 0);
    chk_ctl("br_flush2_hz_ignored", 5'b11100);
    nxt;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("br_flush3", 5'b11100);
    nxt;
    chk_ctl("br_done", 5'b11000);
    chk_cnt("br_cnt", 4'd2);
    nxt;

    // hazard and branch together: bubble first, branch next cycle
    set_in(1, 7, 7, 0, 0, 1, 0, 0);
    chk_ctl("hz_br_bubble", 5'b00010);
    nxt;
    set_in(0, 7, 7, 0, 0, 1, 0, 0);
    chk_ctl("hz_br_flush1", 5'b11100);
    nxt;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("hz_br_flush2", 5'b11100);
    nxt;
    chk_ctl("hz_br_flush3", 5'b11100);
    nxt;
    chk_ctl("hz_br_done", 5'b11000);
    chk_cnt("hz_br_cnt", 4'd3);
    nxt;

    // freeze during the second flush cycle
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    chk_ctl("fz_flush1", 5'b11100);
    nxt;
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    chk_ctl("fz_busy1", 5'b00001);
    for (int i = 0; i < 3; i++) begin
      nxt;
      chk_ctl("fz_busy_n", 5'b00001);
    end
    nxt;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("fz_resume_flush2", 5'b11100);
    nxt;
    chk_ctl("fz_resume_flush3", 5'b11100);
    nxt;
    chk_ctl("fz_done", 5'b11000);
    chk_cnt("fz_cnt", 4'd7);
    nxt;

    // clr_stats, including priority over a same-cycle increment
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    chk_ctl("clr_idle", 5'b11000);
    nxt;
    chk_cnt("clr_cnt", 4'd0);
    set_in(1, 5, 5, 0, 0, 0, 1, 1);
    chk_ctl("busy_over_hazard", 5'b00001);
    nxt;
    chk_cnt("clr_priority_cnt", 4'd0);
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    chk_ctl("sat_freeze", 5'b00001);
    for (int i = 0; i < 20; i++) begin
      nxt;
    end
    chk_cnt("sat_cnt", 4'd15);
    chk_ctl("sat_still_frozen", 5'b00001);

    // asynchronous reset mid-freeze
    #2;
    rst = 1'b1;
    #1;
    chk_ctl("async_rst_ctl", 5'b00110);
    chk_cnt("async_rst_cnt", 4'd0);
    nxt;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("post_rst_run", 5'b11000);
    nxt;

    // asynchronous reset mid-flush discards the remaining flush
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    chk_ctl("rf_flush1", 5'b11100);
    nxt;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("rf_flush2", 5'b11100);
    #1;
    rst = 1'b1;
    #1;
    chk_ctl("rf_rst_ctl", 5'b00110);
    nxt;
    rst = 1'b0;
    #1;
    chk_ctl("rf_no_pending_flush", 5'b11000);
    chk_cnt("rf_cnt", 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
